// File: rtl/mux9_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin pick function for the 9-way arbiter.
package mux9_pkg;

  typedef enum logic {ARB, GRANT} arb_state_t;

  localparam int unsigned NUM_CH   = 9;
  localparam int unsigned DW       = 16;
  localparam logic [3:0]  IDLE_SEL = 4'hF;

  // First requester found scanning ptr, ptr+1, ... modulo NUM_CH; IDLE_SEL if none.
  function automatic logic [3:0] next_rr(input logic [NUM_CH-1:0] req,
                                         input logic [3:0]        ptr);
    logic [3:0]  win;
    logic [3:0]  idx4;
    logic        found;
    int unsigned idx;
    win   = IDLE_SEL;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx  = (32'(ptr) + k) % NUM_CH;
      idx4 = 4'(idx);
      if (!found && req[idx4]) begin
        win   = idx4;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/mux_9to1.sv
// 9:1 data mux; any select outside 0..8 drives all-ones.
module mux_9to1 #(
  parameter int unsigned DW = 16
) (
  input  logic [3:0]    sel,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] e,
  input  logic [DW-1:0] f,
  input  logic [DW-1:0] g,
  input  logic [DW-1:0] h,
  input  logic [DW-1:0] i,
  output logic [DW-1:0] y
);

  // Select one input; idle select yields the all-ones pattern.
  always_comb begin
    y = '1;
    case (sel)
      4'd0:    y = a;
      4'd1:    y = b;
      4'd2:    y = c;
      4'd3:    y = d;
      4'd4:    y = e;
      4'd5:    y = f;
      4'd6:    y = g;
      4'd7:    y = h;
      4'd8:    y = i;
      default: y = '1;
    endcase
  end

endmodule

// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter sharing one DW-bit valid/ready channel among 9 producers,
// with bursts of up to MAX_BURST beats per grant and one idle cycle between grants.
module mux9_rr_arbiter
  import mux9_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic [DW-1:0]     din_0,
  input  logic [DW-1:0]     din_1,
  input  logic [DW-1:0]     din_2,
  input  logic [DW-1:0]     din_3,
  input  logic [DW-1:0]     din_4,
  input  logic [DW-1:0]     din_5,
  input  logic [DW-1:0]     din_6,
  input  logic [DW-1:0]     din_7,
  input  logic [DW-1:0]     din_8,
  output logic [NUM_CH-1:0] ack,
  output logic [NUM_CH-1:0] grant,
  output logic [3:0]        sel,
  output logic [DW-1:0]     out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  if (MAX_BURST < 1) begin : g_bad_burst
    $error("mux9_rr_arbiter: MAX_BURST must be >= 1");
  end

  localparam int unsigned CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);
  localparam logic [3:0]  LAST_CH   = 4'(NUM_CH - 1);

  arb_state_t        state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        winner;
  logic [NUM_CH-1:0] live;
  logic              xfer;

  // grant_q is one-hot or zero, so masking req with it gives req[sel] without indexing.
  assign live      = grant_q & req;
  assign out_valid = |live;
  assign xfer      = out_valid & out_ready;
  assign ack       = xfer ? grant_q : '0;
  assign grant     = grant_q;
  assign sel       = sel_q;
  assign winner    = next_rr(req, ptr_q);

  mux_9to1 #(.DW(DW)) u_mux (
    .sel (sel_q),
    .a   (din_0),
    .b   (din_1),
    .c   (din_2),
    .d   (din_3),
    .e   (din_4),
    .f   (din_5),
    .g   (din_6),
    .h   (din_7),
    .i   (din_8),
    .y   (out_data)
  );

  // Next-state: pick a winner in ARB; in GRANT count beats and release on burst end or withdrawal.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ARB: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = winner;
          grant_d = NUM_CH'(1) << winner;
          cnt_d   = '0;
          ptr_d   = (winner == LAST_CH) ? 4'd0 : winner + 4'd1;
        end
      end
      GRANT: begin
        if (!out_valid || (xfer && cnt_q == LAST_BEAT)) begin
          state_d = ARB;
          sel_d   = IDLE_SEL;
          grant_d = '0;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      sel_q   <= IDLE_SEL;
      ptr_q   <= '0;
      grant_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Self-checking bench for mux9_rr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model (owner / beats taken / rotating pointer).
module tb_mux9_rr_arbiter;

  localparam int MB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  req;
  logic [15:0] d_din [9];
  logic [8:0]  ack;
  logic [8:0]  grant;
  logic [3:0]  sel;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;

  always #5 clk = ~clk;

  mux9_rr_arbiter #(.DW(16), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .din_0     (d_din[0]),
    .din_1     (d_din[1]),
    .din_2     (d_din[2]),
    .din_3     (d_din[3]),
    .din_4     (d_din[4]),
    .din_5     (d_din[5]),
    .din_6     (d_din[6]),
    .din_7     (d_din[7]),
    .din_8     (d_din[8]),
    .ack       (ack),
    .grant     (grant),
    .sel       (sel),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus staged for the next cycle
  logic [8:0]  r_req;
  logic [15:0] r_din [9];
  logic        r_rdy;
  logic [8:0]  last_ack;

  // Reference model: who owns the channel (-1 = none), beats taken, rotation pointer
  int m_owner;
  int m_beats;
  int m_ptr;

  // Fairness tracking
  bit fair_on   = 1'b0;
  bit prev_idle = 1'b1;
  int fair_idx  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [8:0] r, input int p);
    for (int k = 0; k < 9; k++)
      if (r[(p + k) % 9]) return (p + k) % 9;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner  = -1;
    m_beats  = 0;
    m_ptr    = 0;
    last_ack = '0;
  endtask

  // One clock: apply staged inputs at negedge, check outputs, advance the model.
  task automatic step();
    logic [3:0]  e_sel;
    logic [8:0]  e_grant;
    logic        e_valid;
    logic [8:0]  e_ack;
    logic [15:0] e_data;
    int          w;
    @(negedge clk);
    req       = r_req;
    out_ready = r_rdy;
    for (int i = 0; i < 9; i++) d_din[i] = r_din[i];
    #1;
    if (m_owner < 0) begin
      e_sel   = 4'hF;
      e_grant = '0;
      e_valid = 1'b0;
      e_data  = 16'hFFFF;
    end else begin
      e_sel   = 4'(m_owner);
      e_grant = 9'd1 << m_owner;
      e_valid = r_req[m_owner];
      e_data  = r_din[m_owner];
    end
    e_ack = (e_valid && r_rdy) ? e_grant : '0;
    chk("sel", 32'(sel), 32'(e_sel));
    chk("grant", 32'(grant), 32'(e_grant));
    chk("out_valid", 32'(out_valid), 32'(e_valid));
    chk("ack", 32'(ack), 32'(e_ack));
    chk("out_data", 32'(out_data), 32'(e_data));
    if (fair_on && prev_idle && grant != 0) begin
      chk("fair_order", 32'(sel), 32'(fair_idx % 9));
      fair_idx++;
    end
    prev_idle = (grant == 0);
    last_ack = e_ack;
    if (m_owner < 0) begin
      w = rr_pick(r_req, m_ptr);
      if (w >= 0) begin
        m_owner = w;
        m_beats = 0;
        m_ptr   = (w + 1) % 9;
      end
    end else if (!r_req[m_owner]) begin
      m_owner = -1;
    end else if (r_rdy) begin
      m_beats++;
      if (m_beats == MB) m_owner = -1;
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must go idle at once.
  task automatic reset_now();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sel", 32'(sel), 32'hF);
    chk("rst_data", 32'(out_data), 32'hFFFF);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    r_req = '0;
    r_rdy = 1'b0;
    model_reset();
    @(negedge clk);
    req       = '0;
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < 9; i++) begin
      if (last_ack[i]) begin
        r_req[i] = 1'($urandom_range(0, 1));
        r_din[i] = 16'($urandom);
      end else if (r_req[i]) begin
        if ($urandom_range(0, 15) == 0) r_req[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        r_req[i] = 1'b1;
        r_din[i] = 16'($urandom);
      end
    end
    r_rdy = ($urandom_range(0, 3) != 0);
  endtask

  int acks;

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    r_req     = '0;
    r_rdy     = 1'b0;
    for (int i = 0; i < 9; i++) begin
      d_din[i] = '0;
      r_din[i] = '0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single burst on channel 3, then re-grant after one bubble
    r_req = 9'b0_0000_1000;
    r_din[3] = 16'h1234;
    r_rdy = 1'b1;
    step();
    acks = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (k == 0) chk("burst_sel", 32'(sel), 32'd3);
      if (ack[3] && out_data == 16'h1234) acks++;
    end
    chk("burst_acks", 32'(acks), 32'd4);
    step();
    chk("burst_bubble", 32'(out_valid), 32'd0);
    step();
    chk("burst_regrant", 32'(sel), 32'd3);
    step();

    // Reset in the middle of that burst, then backpressure on channel 2
    reset_now();
    r_req = 9'b0_0000_0100;
    r_din[2] = 16'hABCD;
    r_rdy = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_hold_data", 32'(out_data), 32'hABCD);
    end
    r_rdy = 1'b1;
    step();
    chk("bp_release_ack", 32'(ack), 32'h4);
    step();

    // Withdrawal on channel 5 while channel 6 waits
    reset_now();
    r_req = 9'b0_0010_0000;
    r_din[5] = 16'h5555;
    r_din[6] = 16'h6666;
    r_rdy = 1'b0;
    step();
    step();
    r_req = 9'b0_0100_0000;
    r_rdy = 1'b1;
    step();
    chk("wd_no_ack", 32'(ack), 32'h0);
    step();
    step();
    chk("wd_next_sel", 32'(sel), 32'd6);
    step();

    // Wrap: move pointer to 8, then channels 0 and 8 contend
    reset_now();
    r_req = 9'b0_1000_0000;
    r_rdy = 1'b0;
    step();
    r_req = '0;
    step();
    r_req = 9'b1_0000_0001;
    r_din[0] = 16'h0A0A;
    r_din[8] = 16'h8888;
    r_rdy = 1'b1;
    step();
    step();
    chk("wrap_first", 32'(sel), 32'd8);
    repeat (4) step();
    step();
    chk("wrap_second", 32'(sel), 32'd0);
    repeat (4) step();

    // Fairness with all requesters held
    reset_now();
    for (int i = 0; i < 9; i++) r_din[i] = 16'(16'h1000 * i + i);
    r_req     = 9'h1FF;
    r_rdy     = 1'b1;
    prev_idle = 1'b1;
    fair_idx  = 0;
    fair_on   = 1'b1;
    repeat (50) step();
    fair_on = 1'b0;
    chk("fair_count", 32'(fair_idx), 32'd10);

    // Randomized traffic with a reset part-way through
    reset_now();
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        for (int t = 0; t < 200 && m_owner < 0; t++) begin
          rand_inputs();
          step();
        end
        reset_now();
      end
      rand_inputs();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
